// File: rtl/ctrl_pkg.sv
// Shared types and constants for the accumulator-CPU control sequencer.
package ctrl_pkg;

  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned OPC_HI    = 8;
  localparam int unsigned OPC_LO    = 6;
  localparam int unsigned SUB_HI    = 5;
  localparam int unsigned SUB_LO    = 3;
  localparam int unsigned RS_HI     = 2;
  localparam int unsigned RS_LO     = 0;
  localparam int unsigned IMM_HI    = 5;
  localparam int unsigned IMM_LO    = 0;
  localparam int unsigned ACC_SEL_W = 2;

  localparam logic [ACC_SEL_W-1:0] ACC_SEL_ALU = 2'd0;
  localparam logic [ACC_SEL_W-1:0] ACC_SEL_LUT = 2'd1;
  localparam logic [ACC_SEL_W-1:0] ACC_SEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_MEMWAIT = 3'd5,
    ST_WB      = 3'd6,
    ST_HALT    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU  = 3'b000,
    OP_LDI  = 3'b001,
    OP_LD   = 3'b010,
    OP_ST   = 3'b011,
    OP_MOV  = 3'b100,
    OP_BZ   = 3'b101,
    OP_BR   = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  // Sub-ops 110/111 are reserved and behave as a NOP.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_RSV6 = 3'b110,
    ALU_RSV7 = 3'b111
  } alu_op_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-class decode of the latched IR fields.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  opcode_t                opc_i,
  input  alu_op_t                sub_i,
  output logic                   is_alu_o,
  output logic                   is_mem_o,
  output logic                   is_ld_o,
  output logic                   is_branch_o,
  output logic                   is_bz_o,
  output logic                   is_halt_o,
  output logic                   is_nop_o,
  output logic                   writes_acc_o,
  output logic                   writes_rf_o,
  output logic [ACC_SEL_W-1:0]   acc_sel_o
);

  logic rsv_c;

  // Opcode to class flags; reserved ALU sub-ops only advance the PC.
  always_comb begin
    is_alu_o     = 1'b0;
    is_mem_o     = 1'b0;
    is_ld_o      = 1'b0;
    is_branch_o  = 1'b0;
    is_bz_o      = 1'b0;
    is_halt_o    = 1'b0;
    is_nop_o     = 1'b0;
    writes_acc_o = 1'b0;
    writes_rf_o  = 1'b0;
    acc_sel_o    = ACC_SEL_ALU;
    rsv_c        = (sub_i == ALU_RSV6) || (sub_i == ALU_RSV7);
    case (opc_i)
      OP_ALU: begin
        is_alu_o     = 1'b1;
        is_nop_o     = rsv_c;
        writes_acc_o = ~rsv_c;
      end
      OP_LDI: begin
        writes_acc_o = 1'b1;
        acc_sel_o    = ACC_SEL_LUT;
      end
      OP_LD: begin
        is_mem_o     = 1'b1;
        is_ld_o      = 1'b1;
        writes_acc_o = 1'b1;
        acc_sel_o    = ACC_SEL_MEM;
      end
      OP_ST:   is_mem_o    = 1'b1;
      OP_MOV:  writes_rf_o = 1'b1;
      OP_BZ: begin
        is_branch_o = 1'b1;
        is_bz_o     = 1'b1;
      end
      OP_BR:   is_branch_o = 1'b1;
      OP_HALT: is_halt_o   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM for the 9-bit accumulator CPU.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined;
// otherwise instr_cnt_o/cycle_cnt_o are tied to zero.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [INSTR_W-1:0]   instr_i,
  input  logic                 alu_z_i,
  output logic                 pc_inc_o,
  output logic                 pc_load_o,
  output logic [2:0]           rf_raddr_o,
  output logic [2:0]           rf_waddr_o,
  output logic                 rf_we_o,
  output logic                 acc_we_o,
  output logic [ACC_SEL_W-1:0] acc_sel_o,
  output logic [5:0]           lut_idx_o,
  output logic [2:0]           alu_op_o,
  output logic                 carry_en_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic                 done,
  output logic [CNT_W-1:0]     instr_cnt_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  opcode_t opc;
  alu_op_t sub;
  logic    is_alu, is_mem, is_ld, is_branch, is_bz, is_halt, is_nop;
  logic    writes_acc, writes_rf;

  assign opc = opcode_t'(ir_q[OPC_HI:OPC_LO]);
  assign sub = alu_op_t'(ir_q[SUB_HI:SUB_LO]);

  ctrl_decode u_decode (
    .opc_i        (opc),
    .sub_i        (sub),
    .is_alu_o     (is_alu),
    .is_mem_o     (is_mem),
    .is_ld_o      (is_ld),
    .is_branch_o  (is_branch),
    .is_bz_o      (is_bz),
    .is_halt_o    (is_halt),
    .is_nop_o     (is_nop),
    .writes_acc_o (writes_acc),
    .writes_rf_o  (writes_rf),
    .acc_sel_o    (acc_sel_o)
  );

  // Field outputs follow the latched instruction continuously.
  assign rf_raddr_o = ir_q[RS_HI:RS_LO];
  assign rf_waddr_o = ir_q[RS_HI:RS_LO];
  assign lut_idx_o  = ir_q[IMM_HI:IMM_LO];
  assign alu_op_o   = ir_q[SUB_HI:SUB_LO];
  assign done       = (state_q == ST_HALT);

  // State and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, IR load and per-state strobes.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_inc_o   = 1'b0;
    pc_load_o  = 1'b0;
    rf_we_o    = 1'b0;
    acc_we_o   = 1'b0;
    carry_en_o = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instr_i;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        carry_en_o = is_alu & ~is_nop;
        if (is_branch) begin
          state_d = ST_FETCH;
          if (is_bz && !alu_z_i) pc_inc_o  = 1'b1;
          else                   pc_load_o = 1'b1;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_rd_o = is_ld;
        mem_wr_o = ~is_ld;
        state_d  = is_ld ? ST_MEMWAIT : ST_WB;
      end
      ST_MEMWAIT: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        pc_inc_o = 1'b1;
        acc_we_o = writes_acc;
        rf_we_o  = writes_rf;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             retire_c, busy_c;

  // Saturating retire and busy-cycle counters.
  always_comb begin
    retire_c    = pc_inc_o | pc_load_o | ((state_q == ST_DECODE) & is_halt);
    busy_c      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    instr_cnt_d = instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (retire_c && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + CNT_W'(1);
    if (busy_c && (cycle_cnt_q != '1))   cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instr_cnt_o = instr_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
`else
  assign instr_cnt_o = '0;
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: a timing model pushes expected strobe
// events per instruction; a negedge monitor pops and compares each event.
module tb_ctrl_sequencer;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i;
  logic [8:0]       instr_i;
  logic             alu_z_i;
  logic             pc_inc_o, pc_load_o, rf_we_o, acc_we_o, carry_en_o;
  logic             mem_rd_o, mem_wr_o, done;
  logic [2:0]       rf_raddr_o, rf_waddr_o, alu_op_o;
  logic [1:0]       acc_sel_o;
  logic [5:0]       lut_idx_o;
  logic [CNT_W-1:0] instr_cnt_o, cycle_cnt_o;

  ctrl_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .instr_i     (instr_i),
    .alu_z_i     (alu_z_i),
    .pc_inc_o    (pc_inc_o),
    .pc_load_o   (pc_load_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_we_o     (rf_we_o),
    .acc_we_o    (acc_we_o),
    .acc_sel_o   (acc_sel_o),
    .lut_idx_o   (lut_idx_o),
    .alu_op_o    (alu_op_o),
    .carry_en_o  (carry_en_o),
    .mem_rd_o    (mem_rd_o),
    .mem_wr_o    (mem_wr_o),
    .done        (done),
    .instr_cnt_o (instr_cnt_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int unsigned m_instr, m_cycles;

  // Strobe vector: {pc_inc, pc_load, rf_we, acc_we, carry_en, mem_rd, mem_wr}
  localparam logic [6:0] S_INC   = 7'b1000000;
  localparam logic [6:0] S_LOAD  = 7'b0100000;
  localparam logic [6:0] S_RF    = 7'b0010000;
  localparam logic [6:0] S_ACC   = 7'b0001000;
  localparam logic [6:0] S_CARRY = 7'b0000100;
  localparam logic [6:0] S_RD    = 7'b0000010;
  localparam logic [6:0] S_WR    = 7'b0000001;

  typedef struct packed {
    logic [31:0] cyc;
    logic [6:0]  stb;
    logic [1:0]  sel;
    logic [2:0]  aop;
    logic [2:0]  ra;
    logic [2:0]  wa;
    logic [5:0]  lut;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected strobe event at relative cycle r of an instruction fetched at cycle k.
  task automatic push_ev(input logic [8:0] ins, input int unsigned k, input int r,
                         input logic [6:0] stb, input int max_r);
    ev_t e;
    logic [2:0] opc;
    if (r >= max_r) return;
    opc   = ins[8:6];
    e.cyc = 32'(k + r);
    e.stb = stb;
    e.sel = (opc == 3'd1) ? 2'd1 : (opc == 3'd2) ? 2'd2 : 2'd0;
    e.aop = ins[5:3];
    e.ra  = ins[2:0];
    e.wa  = ins[2:0];
    e.lut = ins[5:0];
    exp_q.push_back(e);
  endtask

  // Instruction-level timing model: strobes at offsets from FETCH, and length.
  task automatic model(input logic [8:0] ins, input int unsigned k, input logic z,
                       input int max_r, output int len);
    logic [2:0] opc, sub;
    opc = ins[8:6];
    sub = ins[5:3];
    case (opc)
      3'd0: begin
        if (sub < 3'd6) begin
          push_ev(ins, k, 2, S_CARRY, max_r);
          push_ev(ins, k, 3, S_INC | S_ACC, max_r);
        end else begin
          push_ev(ins, k, 3, S_INC, max_r);
        end
        len = 4;
      end
      3'd1: begin push_ev(ins, k, 3, S_INC | S_ACC, max_r); len = 4; end
      3'd2: begin
        push_ev(ins, k, 3, S_RD, max_r);
        push_ev(ins, k, 5, S_INC | S_ACC, max_r);
        len = 6;
      end
      3'd3: begin
        push_ev(ins, k, 3, S_WR, max_r);
        push_ev(ins, k, 4, S_INC, max_r);
        len = 5;
      end
      3'd4: begin push_ev(ins, k, 3, S_INC | S_RF, max_r); len = 4; end
      3'd5: begin push_ev(ins, k, 2, z ? S_LOAD : S_INC, max_r); len = 3; end
      3'd6: begin push_ev(ins, k, 2, S_LOAD, max_r); len = 3; end
      default: len = 2;
    endcase
    m_instr  += 1;
    m_cycles += 32'(len);
  endtask

  // Called in the cycle before FETCH; returns in the cycle before the next FETCH.
  // zmode: 0 random zero flag, 1 force 1 in EXEC, 2 force 0 in EXEC.
  task automatic do_instr(input logic [8:0] ins, input int zmode);
    logic zs [0:5];
    int   len;
    for (int r = 0; r < 6; r++) zs[r] = 1'($urandom_range(0, 1));
    if (zmode == 1) zs[2] = 1'b1;
    else if (zmode == 2) zs[2] = 1'b0;
    instr_i = ins;
    model(ins, cyc + 1, zs[2], 99, len);
    for (int r = 0; r < len; r++) begin
      step();
      alu_z_i = zs[r];
    end
    instr_i = 9'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    start_i = 1'b0;
    repeat (n) step();
    reset    = 1'b0;
    m_instr  = 0;
    m_cycles = 0;
  endtask

  task automatic chk_counters(input int unsigned ei, input int unsigned ec);
`ifdef CTRL_PERF_CNT_EN
    chk("instr_cnt", 32'(instr_cnt_o), ei);
    chk("cycle_cnt", 32'(cycle_cnt_o), ec);
`else
    chk("instr_cnt_off", 32'(instr_cnt_o), 32'(ei - ei));
    chk("cycle_cnt_off", 32'(cycle_cnt_o), 32'(ec - ec));
`endif
  endtask

  // Monitor: every cycle with a strobe must match the next expected event.
  ev_t got, want;
  always @(negedge clk) begin
    got.cyc = cyc;
    got.stb = {pc_inc_o, pc_load_o, rf_we_o, acc_we_o, carry_en_o, mem_rd_o, mem_wr_o};
    got.sel = acc_sel_o;
    got.aop = alu_op_o;
    got.ra  = rf_raddr_o;
    got.wa  = rf_waddr_o;
    got.lut = lut_idx_o;
    if (got.stb != 7'd0) begin
      chk("pc_exclusive", 32'(pc_inc_o & pc_load_o), 32'd0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d got stb=%b", cyc, got.stb);
      end else begin
        want = exp_q.pop_front();
        if ((want.stb & S_ACC) == 7'd0) got.sel = want.sel;
        if (got !== want) begin
          bad++;
          $display("FAIL strobe_event got cyc=%0d stb=%b sel=%0d aop=%0d ra=%0d wa=%0d lut=%0d want cyc=%0d stb=%b sel=%0d aop=%0d ra=%0d wa=%0d lut=%0d",
                   got.cyc, got.stb, got.sel, got.aop, got.ra, got.wa, got.lut,
                   want.cyc, want.stb, want.sel, want.aop, want.ra, want.wa, want.lut);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int len;
    logic [8:0] ins;
    reset   = 1'b1;
    start_i = 1'b0;
    instr_i = '0;
    alu_z_i = 1'b0;
    do_reset(3);

    // Reset state
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", 32'({pc_inc_o, pc_load_o, rf_we_o, acc_we_o, carry_en_o, mem_rd_o, mem_wr_o}), 32'd0);
    chk("rst_ir_fields", 32'({rf_raddr_o, rf_waddr_o, lut_idx_o, alu_op_o}), 32'd0);
    chk_counters(0, 0);

    // IDLE holds without start
    repeat (3) step();
    chk("idle_done", 32'(done), 32'd0);
    chk_counters(0, 0);

    // Directed program covering every opcode class
    start_i = 1'b1;
    do_instr(9'b000_000_011, 0);
    do_instr(9'b010_000_010, 0);
    do_instr(9'b011_000_010, 0);
    do_instr(9'b101_000_101, 1);
    do_instr(9'b101_000_101, 2);
    do_instr(9'b100_000_110, 0);
    do_instr(9'b001_101_011, 0);
    do_instr(9'b000_110_001, 0);
    do_instr(9'b000_111_100, 0);
    do_instr(9'b110_010_000, 0);
    do_instr(9'b000_001_111, 0);
    do_instr(9'b111_000_000, 0);
    step();
    chk_counters(m_instr, m_cycles);
    for (int i = 0; i < 20; i++) begin
      chk("halt_done", 32'(done), 32'd1);
      step();
    end

    do_reset(2);
    chk("rst_clears_done", 32'(done), 32'd0);
    chk_counters(0, 0);

    // Reset during MEMWAIT of LD drops the pending write-back
    start_i = 1'b1;
    ins     = 9'b010_000_010;
    instr_i = ins;
    model(ins, cyc + 1, 1'b0, 5, len);
    for (int r = 0; r < 5; r++) begin
      step();
      alu_z_i = 1'($urandom_range(0, 1));
    end
    chk("memwait_ir_live", 32'(rf_raddr_o), 32'd2);
    reset = 1'b1;
    step();
    chk("midrst_acc_we", 32'(acc_we_o), 32'd0);
    chk("midrst_ir_zero", 32'({rf_raddr_o, lut_idx_o}), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    do_reset(2);
    repeat (2) step();

    // Retire and busy-cycle counts for ALU, LDI, BR, HALT
    start_i = 1'b1;
    do_instr(9'b000_010_001, 0);
    do_instr(9'b001_000_111, 0);
    do_instr(9'b110_000_000, 0);
    do_instr(9'b111_000_000, 0);
    step();
    chk("perf_done", 32'(done), 32'd1);
`ifdef CTRL_PERF_CNT_EN
    chk_counters(4, 13);
`else
    chk_counters(0, 0);
`endif

    // Random program terminated by HALT
    do_reset(2);
    start_i = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ins = {3'($urandom_range(0, 6)), 6'($urandom)};
      do_instr(ins, 0);
    end
    do_instr(9'b111_000_000, 0);
    step();
    chk("rand_done", 32'(done), 32'd1);
    chk_counters(m_instr, m_cycles);
    repeat (5) step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
